// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels (operation and response handshakes)
// shared between the issue logic and alu_arbiter.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);

  // Requester 0: operation channel
  logic                  i_r0_valid;
  logic                  o_r0_ready;
  logic [5:0]            i_r0_op;
  logic [DATA_WIDTH-1:0] i_r0_a;
  logic [DATA_WIDTH-1:0] i_r0_b;

  // Requester 0: response channel
  logic                  o_r0_rsp_valid;
  logic [DATA_WIDTH-1:0] o_r0_rsp_data;
  logic                  i_r0_rsp_ready;

  // Requester 1: operation channel
  logic                  i_r1_valid;
  logic                  o_r1_ready;
  logic [5:0]            i_r1_op;
  logic [DATA_WIDTH-1:0] i_r1_a;
  logic [DATA_WIDTH-1:0] i_r1_b;

  // Requester 1: response channel
  logic                  o_r1_rsp_valid;
  logic [DATA_WIDTH-1:0] o_r1_rsp_data;
  logic                  i_r1_rsp_ready;

  // Arbiter side
  modport slave (
    input  i_r0_valid, i_r0_op, i_r0_a, i_r0_b, i_r0_rsp_ready,
    output o_r0_ready, o_r0_rsp_valid, o_r0_rsp_data,
    input  i_r1_valid, i_r1_op, i_r1_a, i_r1_b, i_r1_rsp_ready,
    output o_r1_ready, o_r1_rsp_valid, o_r1_rsp_data
  );

  // Requester side (issue logic / helper units)
  modport master (
    output i_r0_valid, i_r0_op, i_r0_a, i_r0_b, i_r0_rsp_ready,
    input  o_r0_ready, o_r0_rsp_valid, o_r0_rsp_data,
    output i_r1_valid, i_r1_op, i_r1_a, i_r1_b, i_r1_rsp_ready,
    input  o_r1_ready, o_r1_rsp_valid, o_r1_rsp_data
  );

endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the execute stage (r0)
// and a multi-cycle helper (r1). One operation is accepted per cycle; each
// result lands in a one-entry response buffer owned by its requester.
// The combinational alu lives in this file as well.

// Combinational ALU: full-width results, wrap-around add/sub, shift by b[4:0].
module alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [5:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_c
);

  localparam logic [5:0] OP_ALU_ADD  = 6'd0;
  localparam logic [5:0] OP_ALU_SUB  = 6'd1;
  localparam logic [5:0] OP_ALU_AND  = 6'd2;
  localparam logic [5:0] OP_ALU_OR   = 6'd3;
  localparam logic [5:0] OP_ALU_XOR  = 6'd4;
  localparam logic [5:0] OP_ALU_SLL  = 6'd5;
  localparam logic [5:0] OP_ALU_SRL  = 6'd6;
  localparam logic [5:0] OP_ALU_SRA  = 6'd7;
  localparam logic [5:0] OP_ALU_SLT  = 6'd8;
  localparam logic [5:0] OP_ALU_SLTU = 6'd9;
  localparam logic [5:0] OP_ALU_PASB = 6'd10;

  logic [4:0] w_shamt;

  assign w_shamt = i_b[4:0];

  // Opcode decode; unknown opcodes produce zero so nothing stale leaks out
  always_comb begin
    o_c = '0;
    case (i_op)
      OP_ALU_ADD:  o_c = i_a + i_b;
      OP_ALU_SUB:  o_c = i_a - i_b;
      OP_ALU_AND:  o_c = i_a & i_b;
      OP_ALU_OR:   o_c = i_a | i_b;
      OP_ALU_XOR:  o_c = i_a ^ i_b;
      OP_ALU_SLL:  o_c = i_a << w_shamt;
      OP_ALU_SRL:  o_c = i_a >> w_shamt;
      OP_ALU_SRA:  o_c = $unsigned($signed(i_a) >>> w_shamt);
      OP_ALU_SLT:  o_c = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_ALU_SLTU: o_c = {{(DATA_WIDTH-1){1'b0}}, (i_a < i_b)};
      OP_ALU_PASB: o_c = i_b;
      default:     o_c = '0;
    endcase
  end

endmodule

// Two-requester arbiter in front of the shared ALU.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int DATA_WIDTH = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  alu_arbiter_if.slave  bus
);

  // Priority pointer: 0 favours r0, 1 favours r1
  logic                  r_prio;

  // Per-requester response buffers
  logic                  r_rspValid0;
  logic [DATA_WIDTH-1:0] r_rspData0;
  logic                  r_rspValid1;
  logic [DATA_WIDTH-1:0] r_rspData1;

  logic                  w_free0;
  logic                  w_free1;
  logic                  w_rdy0;
  logic                  w_rdy1;
  logic                  w_acc0;
  logic                  w_acc1;
  logic [5:0]            w_aluOp;
  logic [DATA_WIDTH-1:0] w_aluA;
  logic [DATA_WIDTH-1:0] w_aluB;
  logic [DATA_WIDTH-1:0] w_aluC;

  // A slot being drained this cycle counts as free, allowing back-to-back issue
  assign w_free0 = !r_rspValid0 || bus.i_r0_rsp_ready;
  assign w_free1 = !r_rspValid1 || bus.i_r1_rsp_ready;

  // Ready never looks at the requester's own valid, only at the competitor's.
  // A competitor whose slot is full cannot win, so it never blocks the other.
  assign w_rdy0 = !i_rst && w_free0 && (!r_prio || !bus.i_r1_valid || !w_free1);
  assign w_rdy1 = !i_rst && w_free1 && ( r_prio || !bus.i_r0_valid || !w_free0);

  assign w_acc0 = bus.i_r0_valid && w_rdy0;
  assign w_acc1 = bus.i_r1_valid && w_rdy1;

  assign bus.o_r0_ready     = w_rdy0;
  assign bus.o_r1_ready     = w_rdy1;
  assign bus.o_r0_rsp_valid = r_rspValid0;
  assign bus.o_r0_rsp_data  = r_rspData0;
  assign bus.o_r1_rsp_valid = r_rspValid1;
  assign bus.o_r1_rsp_data  = r_rspData1;

  // Operand mux: r1 only when it is accepted, otherwise r0 (result ignored if idle)
  always_comb begin
    w_aluOp = bus.i_r0_op;
    w_aluA  = bus.i_r0_a;
    w_aluB  = bus.i_r0_b;
    if (w_acc1) begin
      w_aluOp = bus.i_r1_op;
      w_aluA  = bus.i_r1_a;
      w_aluB  = bus.i_r1_b;
    end
  end

  alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .i_op (w_aluOp),
    .i_a  (w_aluA),
    .i_b  (w_aluB),
    .o_c  (w_aluC)
  );

  // r0 response buffer: capture on accept, otherwise clear valid when drained
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rspValid0 <= 1'b0;
      r_rspData0  <= '0;
    end else if (w_acc0) begin
      r_rspValid0 <= 1'b1;
      r_rspData0  <= w_aluC;
    end else if (bus.i_r0_rsp_ready) begin
      r_rspValid0 <= 1'b0;
    end
  end

  // r1 response buffer: capture on accept, otherwise clear valid when drained
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rspValid1 <= 1'b0;
      r_rspData1  <= '0;
    end else if (w_acc1) begin
      r_rspValid1 <= 1'b1;
      r_rspData1  <= w_aluC;
    end else if (bus.i_r1_rsp_ready) begin
      r_rspValid1 <= 1'b0;
    end
  end

  // Priority pointer: the requester just served drops to lower priority
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio <= 1'b0;
    end else if (FIXED_PRIO) begin
      r_prio <= 1'b0;
    end else if (w_acc0) begin
      r_prio <= 1'b1;
    end else if (w_acc1) begin
      r_prio <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a vector table driven against a round-robin
// instance, plus a short hand-written sequence on a fixed-priority instance.
module tb_alu_arbiter;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_XOR = 6'd4;
  localparam logic [5:0] OP_SLL = 6'd5;
  localparam logic [5:0] OP_SRA = 6'd7;

  typedef struct {
    logic        chk;
    logic        rst;
    logic        v0;
    logic [5:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        rr0;
    logic        v1;
    logic [5:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        rr1;
    logic        rdy0;
    logic        rdy1;
    logic        rv0;
    logic [31:0] rd0;
    logic        rv1;
    logic [31:0] rd1;
  } vec_t;

  localparam int NVEC = 21;

  logic clk;
  logic rst0;
  logic rst1;
  int   checks;
  int   errors;
  vec_t vecs [NVEC];

  alu_arbiter_if #(.DATA_WIDTH(32)) bus0 ();
  alu_arbiter_if #(.DATA_WIDTH(32)) bus1 ();

  alu_arbiter #(.FIXED_PRIO(1'b0), .DATA_WIDTH(32)) dut0 (
    .i_clk (clk),
    .i_rst (rst0),
    .bus   (bus0)
  );

  alu_arbiter #(.FIXED_PRIO(1'b1), .DATA_WIDTH(32)) dut1 (
    .i_clk (clk),
    .i_rst (rst1),
    .bus   (bus1)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one table row onto the round-robin instance
  task automatic applyStimulus(input vec_t v);
    rst0                = v.rst;
    bus0.i_r0_valid     = v.v0;
    bus0.i_r0_op        = v.op0;
    bus0.i_r0_a         = v.a0;
    bus0.i_r0_b         = v.b0;
    bus0.i_r0_rsp_ready = v.rr0;
    bus0.i_r1_valid     = v.v1;
    bus0.i_r1_op        = v.op1;
    bus0.i_r1_a         = v.a1;
    bus0.i_r1_b         = v.b1;
    bus0.i_r1_rsp_ready = v.rr1;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    rst0 = 1'b1;
    rst1 = 1'b1;
    bus0.i_r0_valid = 1'b0; bus0.i_r0_op = OP_ADD; bus0.i_r0_a = '0; bus0.i_r0_b = '0;
    bus0.i_r1_valid = 1'b0; bus0.i_r1_op = OP_ADD; bus0.i_r1_a = '0; bus0.i_r1_b = '0;
    bus0.i_r0_rsp_ready = 1'b0; bus0.i_r1_rsp_ready = 1'b0;
    bus1.i_r0_valid = 1'b0; bus1.i_r0_op = OP_ADD; bus1.i_r0_a = '0; bus1.i_r0_b = '0;
    bus1.i_r1_valid = 1'b0; bus1.i_r1_op = OP_ADD; bus1.i_r1_a = '0; bus1.i_r1_b = '0;
    bus1.i_r0_rsp_ready = 1'b0; bus1.i_r1_rsp_ready = 1'b0;

    // Each row: inputs for the cycle, ready values seen before the edge, and
    // response-buffer contents left by the earlier edges.
    //           chk   rst   v0    op0     a0            b0            rr0   v1    op1     a1            b1            rr1   rdy0  rdy1  rv0   rd0           rv1   rd1
    // Reset held two cycles with both requesters valid
    vecs[0]  = '{1'b0, 1'b1, 1'b1, OP_ADD, 32'h1,        32'h1,        1'b1, 1'b1, OP_SUB, 32'h1,        32'h1,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, OP_ADD, 32'h1,        32'h1,        1'b1, 1'b1, OP_SUB, 32'h1,        32'h1,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    // Released: r0 wins first, single ADD 1+1
    vecs[2]  = '{1'b1, 1'b0, 1'b1, OP_ADD, 32'h1,        32'h1,        1'b1, 1'b1, OP_SUB, 32'h5,        32'h3,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b1, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h2,        1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b1, 1'b1, OP_SUB, 32'h5,        32'h3,        1'b1, 1'b0, 1'b1, 1'b0, 32'h2,        1'b0, 32'h0};
    // Round-robin contention: r0, r1, r0
    vecs[5]  = '{1'b1, 1'b0, 1'b1, OP_XOR, 32'h101,      32'h10001,    1'b1, 1'b1, OP_SUB, 32'h1,        32'h1,        1'b1, 1'b1, 1'b0, 1'b0, 32'h2,        1'b1, 32'h2};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, OP_XOR, 32'h101,      32'h10001,    1'b1, 1'b1, OP_SUB, 32'h1,        32'h1,        1'b1, 1'b0, 1'b1, 1'b1, 32'h10100,    1'b0, 32'h2};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, OP_XOR, 32'h101,      32'h10001,    1'b1, 1'b1, OP_SUB, 32'h1,        32'h1,        1'b1, 1'b1, 1'b0, 1'b0, 32'h10100,    1'b1, 32'h0};
    // Accept with simultaneous drain, then backpressure on r0 while r1 is served
    vecs[8]  = '{1'b1, 1'b0, 1'b1, OP_SLL, 32'h1,        32'h10,       1'b1, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h10100,    1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, OP_ADD, 32'h7,        32'h8,        1'b0, 1'b1, OP_SRA, 32'hfffffff0, 32'h3,        1'b1, 1'b0, 1'b1, 1'b1, 32'h10000,    1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, OP_ADD, 32'h7,        32'h8,        1'b1, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h10000,    1'b1, 32'hfffffffe};
    vecs[11] = '{1'b1, 1'b0, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b1, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'd15,       1'b1, 32'hfffffffe};
    // r1 streams four ADDs, draining every cycle
    vecs[12] = '{1'b1, 1'b0, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b1, 1'b1, OP_ADD, 32'd1,        32'd2,        1'b1, 1'b0, 1'b1, 1'b0, 32'd15,       1'b0, 32'hfffffffe};
    vecs[13] = '{1'b1, 1'b0, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b1, 1'b1, OP_ADD, 32'd10,       32'd20,       1'b1, 1'b1, 1'b1, 1'b0, 32'd15,       1'b1, 32'd3};
    vecs[14] = '{1'b1, 1'b0, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b1, 1'b1, OP_ADD, 32'hffffffff, 32'h1,        1'b1, 1'b1, 1'b1, 1'b0, 32'd15,       1'b1, 32'd30};
    vecs[15] = '{1'b1, 1'b0, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b1, 1'b1, OP_ADD, 32'h7fffffff, 32'h1,        1'b1, 1'b1, 1'b1, 1'b0, 32'd15,       1'b1, 32'h0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b1, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'd15,       1'b1, 32'h80000000};
    // Reset in the cycle after an accepted SRA
    vecs[17] = '{1'b1, 1'b0, 1'b1, OP_SRA, 32'h80000000, 32'h1f,       1'b0, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'd15,       1'b0, 32'h80000000};
    vecs[18] = '{1'b1, 1'b1, 1'b1, OP_SRA, 32'h80000000, 32'h1f,       1'b0, 1'b1, OP_SUB, 32'h1,        32'h1,        1'b1, 1'b0, 1'b0, 1'b1, 32'hffffffff, 1'b0, 32'h80000000};
    vecs[19] = '{1'b1, 1'b0, 1'b1, OP_ADD, 32'd2,        32'd3,        1'b1, 1'b1, OP_SUB, 32'd9,        32'd4,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[20] = '{1'b1, 1'b0, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b1, 1'b0, OP_ADD, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'd5,        1'b0, 32'h0};

    // Round-robin table: drive after the falling edge, sample 1 unit later
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d rdy0", i), {31'b0, bus0.o_r0_ready}, {31'b0, vecs[i].rdy0});
      checkOutput($sformatf("v%0d rdy1", i), {31'b0, bus0.o_r1_ready}, {31'b0, vecs[i].rdy1});
      if (vecs[i].chk) begin
        checkOutput($sformatf("v%0d rsp_valid0", i), {31'b0, bus0.o_r0_rsp_valid}, {31'b0, vecs[i].rv0});
        checkOutput($sformatf("v%0d rsp_data0", i), bus0.o_r0_rsp_data, vecs[i].rd0);
        checkOutput($sformatf("v%0d rsp_valid1", i), {31'b0, bus0.o_r1_rsp_valid}, {31'b0, vecs[i].rv1});
        checkOutput($sformatf("v%0d rsp_data1", i), bus0.o_r1_rsp_data, vecs[i].rd1);
      end
    end

    // Fixed-priority instance: r1 must wait until r0 drops valid
    @(negedge clk);
    rst1 = 1'b1;
    bus1.i_r0_valid = 1'b1; bus1.i_r0_op = OP_XOR; bus1.i_r0_a = 32'h101; bus1.i_r0_b = 32'h10001;
    bus1.i_r1_valid = 1'b1; bus1.i_r1_op = OP_SUB; bus1.i_r1_a = 32'h1;   bus1.i_r1_b = 32'h1;
    bus1.i_r0_rsp_ready = 1'b1; bus1.i_r1_rsp_ready = 1'b1;
    #1;
    checkOutput("fp rst rdy0", {31'b0, bus1.o_r0_ready}, 32'h0);
    checkOutput("fp rst rdy1", {31'b0, bus1.o_r1_ready}, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("fp rst rsp_valid0", {31'b0, bus1.o_r0_rsp_valid}, 32'h0);
    checkOutput("fp rst rsp_valid1", {31'b0, bus1.o_r1_rsp_valid}, 32'h0);
    checkOutput("fp rst rsp_data0", bus1.o_r0_rsp_data, 32'h0);
    checkOutput("fp rst rsp_data1", bus1.o_r1_rsp_data, 32'h0);
    rst1 = 1'b0;
    #1;
    checkOutput("fp c0 rdy0", {31'b0, bus1.o_r0_ready}, 32'h1);
    checkOutput("fp c0 rdy1", {31'b0, bus1.o_r1_ready}, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("fp c1 rdy0", {31'b0, bus1.o_r0_ready}, 32'h1);
    checkOutput("fp c1 rdy1", {31'b0, bus1.o_r1_ready}, 32'h0);
    checkOutput("fp c1 rsp_valid0", {31'b0, bus1.o_r0_rsp_valid}, 32'h1);
    checkOutput("fp c1 rsp_data0", bus1.o_r0_rsp_data, 32'h10100);
    @(negedge clk);
    #1;
    checkOutput("fp c2 rdy1", {31'b0, bus1.o_r1_ready}, 32'h0);
    bus1.i_r0_valid = 1'b0;
    #1;
    checkOutput("fp c2 rdy1 after r0 drops", {31'b0, bus1.o_r1_ready}, 32'h1);
    @(negedge clk);
    bus1.i_r1_valid = 1'b0;
    #1;
    checkOutput("fp c3 rsp_valid1", {31'b0, bus1.o_r1_rsp_valid}, 32'h1);
    checkOutput("fp c3 rsp_data1", bus1.o_r1_rsp_data, 32'h0);
    checkOutput("fp c3 rsp_valid0", {31'b0, bus1.o_r0_rsp_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
